// File: rtl/alu16_pkg.sv
// ----------------------------------------------------------------------------
// alu16_pkg : operand/count widths and op-code encoding for the bit-serial ALU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu16_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_SUB  = 3'b001;
  localparam op_t OP_AND  = 3'b010;
  localparam op_t OP_OR   = 3'b011;
  localparam op_t OP_XOR  = 3'b100;
  localparam op_t OP_NAND = 3'b101;
  localparam op_t OP_NOR  = 3'b110;
  localparam op_t OP_XNOR = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu16_bitslice.sv
// ----------------------------------------------------------------------------
// alu16_bitslice : one-bit combinational ALU slice (result bit and carry out)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu16_bitslice
  import alu16_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  input  op_t  i_op,
  output logic o_bit,
  output logic o_cout
);

  logic w_b;

  always_comb begin
    o_bit  = 1'b0;
    o_cout = 1'b0;
    // subtraction is A + ~B with the carry chain seeded to 1
    w_b    = (i_op == OP_SUB) ? ~i_b : i_b;
    case (i_op)
      OP_ADD, OP_SUB: begin
        o_bit  = i_a ^ w_b ^ i_cin;
        o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);
      end
      OP_AND:  o_bit = i_a & i_b;
      OP_OR:   o_bit = i_a | i_b;
      OP_XOR:  o_bit = i_a ^ i_b;
      OP_NAND: o_bit = ~(i_a & i_b);
      OP_NOR:  o_bit = ~(i_a | i_b);
      OP_XNOR: o_bit = ~(i_a ^ i_b);
      default: o_bit = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu16.sv
// ----------------------------------------------------------------------------
// alu16 : bit-serial 16-bit ALU, one result bit per clock, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu16 #(
  parameter int WIDTH = alu16_pkg::WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         on,
  input  logic [WIDTH-1:0]             ina,
  input  logic [WIDTH-1:0]             inb,
  input  logic [2:0]                   op,
  output logic [WIDTH:0]               out,
  output logic [alu16_pkg::CNT_W-1:0]  count
);

  import alu16_pkg::*;

  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_BUSY = 1'b1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_t              r_op;
  logic             r_carry;
  logic [WIDTH-1:0] r_word;
  logic             r_flag;
  logic [CNT_W-1:0] r_count;

  logic             w_bit;
  logic             w_cout;

  assign w_last = (r_count == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (on)     w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE:  w_load = on;
      S_BUSY:  w_step = 1'b1;
      default: ;
    endcase
  end

  alu16_bitslice u_slice (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .i_op   (r_op),
    .o_bit  (w_bit),
    .o_cout (w_cout)
  );

  // operands shift right so the slice always sees the current bit at index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_carry <= 1'b0;
      r_word  <= '0;
      r_flag  <= 1'b0;
      r_count <= '0;
    end else if (w_load) begin
      r_a     <= ina;
      r_b     <= inb;
      r_op    <= op;
      r_carry <= (op == OP_SUB);
      r_word  <= '0;
      r_flag  <= 1'b0;
      r_count <= '0;
    end else if (w_step) begin
      r_a             <= r_a >> 1;
      r_b             <= r_b >> 1;
      r_carry         <= w_cout;
      r_word[r_count] <= w_bit;
      r_count         <= r_count + 1'b1;
      if (w_last) begin
        r_flag <= w_cout;
      end
    end
  end

  assign out   = {r_flag, r_word};
  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu16.sv
// ----------------------------------------------------------------------------
// tb_alu16 : directed self-checking bench for the bit-serial ALU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu16;

  logic        clk;
  logic        rst;
  logic        on;
  logic [15:0] ina;
  logic [15:0] inb;
  logic [2:0]  op;
  logic [16:0] out;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  alu16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .on    (on),
    .ina   (ina),
    .inb   (inb),
    .op    (op),
    .out   (out),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the start edge is the next rising edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                        input logic [16:0] exp, input string tag);
    ina = a; inb = b; op = o; on = 1'b1;
    @(negedge clk);
    on = 1'b0;
    repeat (16) @(negedge clk);
    check({tag, " result"}, out, exp);
    check({tag, " count"}, {13'd0, count}, 17'd0);
  endtask

  initial begin
    logic [15:0] mask;
    rst = 1'b1; on = 1'b0; ina = 16'h0; inb = 16'h0; op = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    check("reset out", out, 17'h00000);
    check("reset count", {13'd0, count}, 17'd0);
    repeat (3) @(negedge clk);
    check("idle out", out, 17'h00000);
    check("idle count", {13'd0, count}, 17'd0);

    // ADD with per-edge count and partial-result tracking
    ina = 16'h7002; inb = 16'h8003; op = 3'b000; on = 1'b1;
    @(negedge clk);
    on = 1'b0;
    check("add start count", {13'd0, count}, 17'd0);
    check("add start out", out, 17'h00000);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      mask = 16'((17'd1 << i) - 17'd1);
      check("add step count", {13'd0, count}, 17'(i % 16));
      if (i < 16) check("add partial", out, {1'b0, 16'hF005 & mask});
    end
    check("add result", out, 17'h0F005);

    run_op(16'hFFFF, 16'h0001, 3'b000, 17'h10000, "add ovf");
    run_op(16'h7002, 16'h8003, 3'b001, 17'h0EFFF, "sub borrow");
    run_op(16'h0005, 16'h0003, 3'b001, 17'h10002, "sub no-borrow");
    run_op(16'hF0F0, 16'hFF00, 3'b010, 17'h0F000, "and");
    run_op(16'hF0F0, 16'hFF00, 3'b011, 17'h0FFF0, "or");
    run_op(16'hF0F0, 16'hFF00, 3'b100, 17'h00FF0, "xor");
    run_op(16'hF0F0, 16'hFF00, 3'b101, 17'h00FFF, "nand");
    run_op(16'hF0F0, 16'hFF00, 3'b110, 17'h0000F, "nor");
    run_op(16'hF0F0, 16'hFF00, 3'b111, 17'h0F00F, "xnor");

    // operands and on disturbed mid-operation
    ina = 16'h1234; inb = 16'h1111; op = 3'b000; on = 1'b1;
    @(negedge clk);
    on = 1'b0;
    repeat (5) @(negedge clk);
    on = 1'b1; ina = 16'hFFFF; inb = 16'h0000; op = 3'b011;
    repeat (3) @(negedge clk);
    on = 1'b0;
    repeat (8) @(negedge clk);
    check("robust result", out, 17'h02345);
    check("robust count", {13'd0, count}, 17'd0);

    // on held high: back-to-back operations
    ina = 16'h0001; inb = 16'h0002; op = 3'b000; on = 1'b1;
    repeat (17) @(negedge clk);
    check("b2b first", out, 17'h00003);
    repeat (2) @(negedge clk);
    check("b2b restart count", {13'd0, count}, 17'd1);
    on = 1'b0;
    repeat (15) @(negedge clk);
    check("b2b second", out, 17'h00003);

    // reset during an operation at count=7
    ina = 16'hFFFF; inb = 16'hFFFF; op = 3'b000; on = 1'b1;
    @(negedge clk);
    on = 1'b0;
    repeat (7) @(negedge clk);
    check("abort pre count", {13'd0, count}, 17'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort out", out, 17'h00000);
    check("abort count", {13'd0, count}, 17'd0);
    repeat (20) @(negedge clk);
    check("abort no-complete out", out, 17'h00000);
    check("abort no-complete count", {13'd0, count}, 17'd0);

    // responds to on right after reset release
    run_op(16'h0005, 16'h0003, 3'b000, 17'h00008, "post-reset add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
